// File: rtl/uartx_if.sv
// IO-bus register port of uartx, plus read-only taps of the TX/RX FSM states.
interface uartx_if;
  // io_write and io_read are single-cycle strobes qualified by io_addr. There is
  // no back-pressure: a strobe is accepted in the cycle it is high, and io_rdata
  // is combinational from io_addr during that same cycle.
  logic [3:0] io_addr;
  logic       io_write;
  logic       io_read;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic [1:0] dbg_tx_state;
  logic [1:0] dbg_rx_state;

  modport master (output io_addr, io_write, io_read, io_wdata,
                  input  io_rdata, dbg_tx_state, dbg_rx_state);
  modport slave  (input  io_addr, io_write, io_read, io_wdata,
                  output io_rdata, dbg_tx_state, dbg_rx_state);
endinterface

// File: rtl/uartx.sv
// UART with RX/TX FIFOs, programmable divisor, 1/2 stop bits, sticky errors
// and a maskable registered interrupt on the io_* register bus.
module uartx #(
  parameter int               DIV_W     = 16,
  parameter int               RX_DEPTH  = 4,
  parameter int               TX_DEPTH  = 4,
  parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(104)
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   rx,
  output logic   tx,
  output logic   interrupt,
  uartx_if.slave io
);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TXA = $clog2(TX_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [DIV_W-1:0] div_q, div_d, div_eff;
  logic [15:0]      div16, div16_new;
  logic [2:0]       ie_q, ie_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [2:0]       flags_q, flags_d;  // {tx_overflow, framing_err, rx_overrun}
  logic             irq_q, irq_d;

  logic wr_data, rd_data, rd_stat;
  assign wr_data = io.io_write && (io.io_addr == 4'd0);
  assign rd_data = io.io_read  && (io.io_addr == 4'd0);
  assign rd_stat = io.io_read  && (io.io_addr == 4'd1);
  assign div16   = 16'(div_q);
  assign div_eff = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;

  // FIFOs: pointers carry one wrap bit above the index
  logic [7:0]  txm_q [TX_DEPTH];
  logic [7:0]  rxm_q [RX_DEPTH];
  logic [TXA:0] txw_q, txr_q;
  logic [RXA:0] rxw_q, rxr_q;
  logic tx_empty, tx_full, tx_push, tx_pop, tx_idle;
  logic rx_empty, rx_full, rx_push, rx_pop;
  assign tx_empty = (txw_q == txr_q);
  assign tx_full  = (txw_q[TXA-1:0] == txr_q[TXA-1:0]) && (txw_q[TXA] != txr_q[TXA]);
  assign rx_empty = (rxw_q == rxr_q);
  assign rx_full  = (rxw_q[RXA-1:0] == rxr_q[RXA-1:0]) && (rxw_q[RXA] != rxr_q[RXA]);
  assign tx_push  = wr_data && (!tx_full || tx_pop);
  assign rx_pop   = rd_data && !rx_empty;

  // ---------------- TX engine ----------------
  state_e           tx_st_q, tx_st_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_div_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_sh_q;
  logic             tx_two_q, tx_sb_q, tx_end, tx_line;
  assign tx_end = (tx_cnt_q == tx_div_q - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) tx_st_q <= S_IDLE;
    else        tx_st_q <= tx_st_d;
  end

  always_comb begin
    tx_st_d = tx_st_q;
    case (tx_st_q)
      S_IDLE:  if (!tx_empty) tx_st_d = S_START;
      S_START: if (tx_end) tx_st_d = S_DATA;
      S_DATA:  if (tx_end && tx_bit_q == 3'd7) tx_st_d = S_STOP;
      S_STOP:  if (tx_end && (tx_sb_q || !tx_two_q)) tx_st_d = tx_empty ? S_IDLE : S_START;
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    tx_pop  = 1'b0;
    case (tx_st_q)
      S_IDLE:  tx_pop  = !tx_empty;
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_sh_q[0];
      S_STOP:  tx_pop  = tx_end && (tx_sb_q || !tx_two_q) && !tx_empty;
      default: ;
    endcase
  end
  assign tx_idle = tx_empty && (tx_st_q == S_IDLE);
  assign tx      = ctrl_q[1] ? 1'b1 : tx_line;

  // Divisor and stop-bit count are latched per frame so mid-frame writes are safe
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_cnt_q <= '0; tx_div_q <= DIV_W'(2); tx_bit_q <= '0;
      tx_sh_q  <= '0; tx_two_q <= 1'b0;      tx_sb_q  <= 1'b0;
    end else if (tx_pop) begin
      tx_cnt_q <= '0; tx_div_q <= div_eff; tx_bit_q <= '0;
      tx_sh_q  <= txm_q[txr_q[TXA-1:0]];   tx_two_q <= ctrl_q[0]; tx_sb_q <= 1'b0;
    end else if (tx_st_q != S_IDLE) begin
      if (tx_end) begin
        tx_cnt_q <= '0;
        if (tx_st_q == S_DATA) begin
          tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
          tx_bit_q <= tx_bit_q + 3'd1;
        end
        if (tx_st_q == S_STOP) tx_sb_q <= 1'b1;
      end else begin
        tx_cnt_q <= tx_cnt_q + DIV_W'(1);
      end
    end
  end

  // ---------------- RX engine ----------------
  state_e           rx_st_q, rx_st_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_div_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_sh_q;
  logic             s1_q, s2_q, rx_end, rx_half, rx_done, ferr_set, ovr_set;
  assign rx_end  = (rx_cnt_q == rx_div_q - DIV_W'(1));
  assign rx_half = (rx_cnt_q == (rx_div_q >> 1) - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_st_q <= S_IDLE; s1_q <= 1'b1; s2_q <= 1'b1;
    end else begin
      rx_st_q <= rx_st_d; s1_q <= ctrl_q[1] ? tx_line : rx; s2_q <= s1_q;
    end
  end

  always_comb begin
    rx_st_d = rx_st_q;
    case (rx_st_q)
      S_IDLE:  if (!s2_q) rx_st_d = S_START;
      S_START: if (rx_half) rx_st_d = s2_q ? S_IDLE : S_DATA;
      S_DATA:  if (rx_end && rx_bit_q == 3'd7) rx_st_d = S_STOP;
      S_STOP:  if (rx_end) rx_st_d = S_IDLE;
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done  = (rx_st_q == S_STOP) && rx_end;
    rx_push  = rx_done && s2_q && (!rx_full || rx_pop);
    ferr_set = rx_done && !s2_q;
    ovr_set  = rx_done && s2_q && rx_full && !rx_pop;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_cnt_q <= '0; rx_div_q <= DIV_W'(2); rx_bit_q <= '0; rx_sh_q <= '0;
    end else if (rx_st_q == S_IDLE) begin
      rx_cnt_q <= '0; rx_bit_q <= '0;
      if (!s2_q) rx_div_q <= div_eff;
    end else if ((rx_st_q == S_START && rx_half) || rx_end) begin
      rx_cnt_q <= '0;
      if (rx_st_q == S_DATA) begin
        rx_sh_q  <= {s2_q, rx_sh_q[7:1]};
        rx_bit_q <= rx_bit_q + 3'd1;
      end
    end else begin
      rx_cnt_q <= rx_cnt_q + DIV_W'(1);
    end
  end

  // ---------------- FIFO storage and registers ----------------
  always_ff @(posedge clk) begin
    if (tx_push) txm_q[txw_q[TXA-1:0]] <= io.io_wdata;
    if (rx_push) rxm_q[rxw_q[RXA-1:0]] <= rx_sh_q;
  end

  always_comb begin
    ie_d      = ie_q;
    ctrl_d    = ctrl_q;
    div16_new = div16;
    if (io.io_write) begin
      case (io.io_addr)
        4'd2: ie_d            = io.io_wdata[2:0];
        4'd3: div16_new[7:0]  = io.io_wdata;
        4'd4: div16_new[15:8] = io.io_wdata;
        4'd5: ctrl_d          = io.io_wdata[1:0];
        default: ;
      endcase
    end
    div_d   = div16_new[DIV_W-1:0];
    flags_d = (rd_stat ? 3'b000 : flags_q) | {wr_data && !tx_push, ferr_set, ovr_set};
    irq_d   = (ie_q[0] && !rx_empty) || (ie_q[1] && !tx_full) || (ie_q[2] && (|flags_q));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= RESET_DIV; ie_q <= '0; ctrl_q <= '0; flags_q <= '0; irq_q <= 1'b0;
      txw_q <= '0; txr_q <= '0; rxw_q <= '0; rxr_q <= '0;
    end else begin
      div_q <= div_d; ie_q <= ie_d; ctrl_q <= ctrl_d; flags_q <= flags_d; irq_q <= irq_d;
      if (tx_push) txw_q <= txw_q + 1'b1;
      if (tx_pop)  txr_q <= txr_q + 1'b1;
      if (rx_push) rxw_q <= rxw_q + 1'b1;
      if (rx_pop)  rxr_q <= rxr_q + 1'b1;
    end
  end
  assign interrupt = irq_q;

  always_comb begin
    io.io_rdata = 8'h00;
    case (io.io_addr)
      4'd0: io.io_rdata = rx_empty ? 8'h00 : rxm_q[rxr_q[RXA-1:0]];
      4'd1: io.io_rdata = {2'b00, flags_q, tx_idle, tx_full, !rx_empty};
      4'd2: io.io_rdata = {5'd0, ie_q};
      4'd3: io.io_rdata = div16[7:0];
      4'd4: io.io_rdata = div16[15:8];
      4'd5: io.io_rdata = {6'd0, ctrl_q};
      default: ;
    endcase
  end
  assign io.dbg_tx_state = tx_st_q;
  assign io.dbg_rx_state = rx_st_q;
endmodule

// File: tb/tb_uartx.sv
// Self-checking bench for uartx: directed register/timing tests plus random
// RX frames and loopback traffic checked against a queue-based byte model.
module tb_uartx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic tx, interrupt;
  uartx_if io();

  uartx dut (.clk(clk), .reset(reset), .rx(rx), .tx(tx), .interrupt(interrupt), .io(io));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_seen[$];
  bit mon_en = 1'b0;
  int mon_div = 8;
  logic [7:0] mon_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic io_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    io.io_addr = a; io.io_wdata = d; io.io_write = 1'b1;
    @(negedge clk);
    io.io_write = 1'b0;
  endtask

  task automatic io_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    io.io_addr = a; io.io_read = 1'b1;
    #1 d = io.io_rdata;
    @(negedge clk);
    io.io_read = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    io_rd(a, d);
    check(tag, d, exp);
  endtask

  // Drive one serial frame on the rx pin with an explicit stop-bit value.
  task automatic inject(input logic [7:0] b, input logic stop_v, input int div);
    logic [9:0] f;
    f = {stop_v, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (div) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    while (interrupt !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    check(tag, interrupt, 1);
  endtask

  task automatic wait_tx_low(input string tag, input int budget);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk); n++;
    end
    check(tag, tx, 0);
  endtask

  // Mid-bit decoder of the tx pin, used while mon_en is set.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        repeat (mon_div / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_div) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (mon_div) @(negedge clk);
        tx_seen.push_back(mon_b);
      end
    end
  end

  initial begin
    logic [7:0] d, b;
    logic [9:0] frame;
    int eff, dv, n_kept;
    logic st, ovr;

    io.io_addr = 4'd0; io.io_write = 1'b0; io.io_read = 1'b0; io.io_wdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_irq", interrupt, 0);
    rd_check("reset_status", 4'd1, 8'h04);
    rd_check("reset_divlo", 4'd3, 8'h68);
    rd_check("reset_divhi", 4'd4, 8'h00);
    rd_check("reset_ie", 4'd2, 8'h00);
    rd_check("reset_ctrl", 4'd5, 8'h00);
    rd_check("empty_data_read", 4'd0, 8'h00);
    rd_check("unmapped_read", 4'd9, 8'h00);
    rd_check("status_after_empty_read", 4'd1, 8'h04);

    // Exact bit timing of 0x55 at DIV=4
    io_wr(4'd3, 8'd4);
    io_wr(4'd4, 8'd0);
    io_wr(4'd0, 8'h55);
    io.io_addr = 4'd1;
    wait_tx_low("tx55_start", 20);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 40; k++) begin
      check("tx55_bit", tx, frame[k / 4]);
      if (k == 20) check("tx55_busy", io.io_rdata[2], 0);
      @(negedge clk);
    end
    check("tx55_idle_line", tx, 1);
    check("tx55_idle_status", io.io_rdata[2], 1);

    // TX overflow: one byte in flight, four queued, fifth dropped
    io_wr(4'd3, 8'd8);
    mon_div = 8;
    mon_en = 1'b1;
    tx_seen.delete();
    io_wr(4'd0, 8'h11);
    wait_tx_low("ovf_first_start", 20);
    io_wr(4'd0, 8'h22); io_wr(4'd0, 8'h33); io_wr(4'd0, 8'h44); io_wr(4'd0, 8'h55);
    io_wr(4'd0, 8'hFF);
    rd_check("ovf_status", 4'd1, 8'h22);
    repeat (480) @(negedge clk);
    mon_en = 1'b0;
    check("ovf_frame_count", tx_seen.size(), 5);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++)
      if (i < tx_seen.size()) check("ovf_frame_byte", tx_seen[i], exp_q[i]);
    rd_check("ovf_status_cleared", 4'd1, 8'h04);

    // Loopback with rx_nonempty interrupt
    io_wr(4'd5, 8'h02);
    io_wr(4'd2, 8'h01);
    io_wr(4'd0, 8'hA5);
    io_wr(4'd0, 8'h3C);
    repeat (20) @(negedge clk);
    check("loop_pin_held", tx, 1);
    wait_irq("loop_irq1", 200);
    rd_check("loop_byte1", 4'd0, 8'hA5);
    repeat (2) @(negedge clk);
    check("loop_irq_drop1", interrupt, 0);
    wait_irq("loop_irq2", 200);
    rd_check("loop_byte2", 4'd0, 8'h3C);
    repeat (2) @(negedge clk);
    check("loop_irq_drop2", interrupt, 0);
    io_wr(4'd5, 8'h00);
    io_wr(4'd2, 8'h00);

    // RX overrun: five frames, no reads
    exp_q.delete();
    ovr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      inject(b, 1'b1, 8);
      if (exp_q.size() < 4) exp_q.push_back(b);
      else ovr = 1'b1;
    end
    rd_check("ovr_status", 4'd1, {4'b0000, ovr, 3'b101});
    rd_check("ovr_status_again", 4'd1, 8'h05);
    n_kept = exp_q.size();
    for (int i = 0; i < n_kept; i++) rd_check("ovr_fifo_order", 4'd0, exp_q.pop_front());
    rd_check("ovr_drained", 4'd1, 8'h04);

    // Framing error with error interrupt
    io_wr(4'd2, 8'h04);
    inject(8'h5A, 1'b0, 8);
    check("ferr_irq", interrupt, 1);
    rd_check("ferr_status", 4'd1, 8'h14);
    repeat (2) @(negedge clk);
    check("ferr_irq_clear", interrupt, 0);
    rd_check("ferr_no_push", 4'd1, 8'h04);
    io_wr(4'd2, 8'h00);

    // Random RX frames, random divisor (0 and 1 behave as 2), random bad stop
    for (int it = 0; it < 12; it++) begin
      dv  = $urandom_range(0, 12);
      eff = (dv < 2) ? 2 : dv;
      b   = 8'($urandom);
      st  = ($urandom_range(0, 3) != 0);
      io_wr(4'd3, 8'(dv));
      inject(b, st, eff);
      if (st) exp_q.push_back(b);
      rd_check("rand_rx_status", 4'd1, {3'b000, !st, 3'b010, st} | 8'h04);
      if (st) rd_check("rand_rx_data", 4'd0, exp_q.pop_front());
    end

    // Random loopback traffic with random stop count
    io_wr(4'd2, 8'h01);
    for (int it = 0; it < 4; it++) begin
      dv = $urandom_range(2, 10);
      b  = 8'($urandom);
      io_wr(4'd3, 8'(dv));
      io_wr(4'd5, 8'(2 + $urandom_range(0, 1)));
      io_wr(4'd0, b);
      wait_irq("rand_loop_irq", 14 * dv + 40);
      rd_check("rand_loop_data", 4'd0, b);
      repeat (2 * dv) @(negedge clk);
    end
    io_wr(4'd5, 8'h00);

    // Reset in the middle of a transmit
    io_wr(4'd3, 8'd16);
    io_wr(4'd2, 8'h02);
    io_wr(4'd0, 8'h0F);
    io_wr(4'd0, 8'hF0);
    wait_tx_low("rst_frame_start", 20);
    repeat (5) @(negedge clk);
    check("rst_pre_tx_low", tx, 0);
    check("rst_pre_irq", interrupt, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_high", tx, 1);
    check("rst_irq_low", interrupt, 0);
    reset = 1'b1;
    rd_check("rst_divlo", 4'd3, 8'h68);
    rd_check("rst_divhi", 4'd4, 8'h00);
    rd_check("rst_status", 4'd1, 8'h04);
    check("rst_irq_after", interrupt, 0);
    repeat (100) @(negedge clk);
    check("rst_no_more_frames", tx, 1);
    rd_check("rst_rx_empty", 4'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
